// File: rtl/button_pulse_gen_pkg.sv
// Shared state encoding, counter width and parameter defaults for button_pulse_gen.
package button_pulse_gen_pkg;

   localparam int unsigned CNT_W               = 8;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
   localparam int unsigned REPEAT_CYCLES_DEF   = 10;

   // Encoding is visible on the lab LEDs, so values are fixed.
   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b10,
      RELEASE_WAIT = 2'b11
   } state_t;

endpackage

// File: rtl/button_pulse_gen_sync_2ff.sv
// Two-flop synchronizer that brings the raw asynchronous button level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // NOTE: non-blocking assignments so r_sync takes r_meta's pre-edge value (a true 2-stage shift).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced pushbutton to single-cycle count-enable pulse generator.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_pulse_gen
   import button_pulse_gen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   output logic       w,
   output logic       btn_level,
   output logic [1:0] state
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
       REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_param_check
      $error("button_pulse_gen: DEBOUNCE_CYCLES and REPEAT_CYCLES must be in 1..255");
   end

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_btn_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_press_pulse;
   logic             w_w_nxt;
   logic             r_w;
   logic             r_btn_level;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (btn),
      .o_q   (w_btn_s)
   );

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_pulse = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_btn_s) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!w_btn_s) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DB_LAST) begin
               w_state_nxt   = PRESSED;
               w_cnt_nxt     = '0;
               w_press_pulse = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!w_btn_s) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A return to 1 is a release glitch: resume the press without a new pulse.
            if (w_btn_s) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DB_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] r_rpt_cnt;
   logic [CNT_W-1:0] w_rpt_cnt_nxt;
   logic             w_rpt_pulse;

   // Counts only while staying in PRESSED; any exit (including a glitch) restarts it.
   always_comb begin
      w_rpt_cnt_nxt = '0;
      w_rpt_pulse   = 1'b0;
      if (r_state == PRESSED && w_state_nxt == PRESSED) begin
         if (r_rpt_cnt == RPT_LAST) begin
            w_rpt_pulse = 1'b1;
         end else begin
            w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rpt_cnt <= '0;
      end else begin
         r_rpt_cnt <= w_rpt_cnt_nxt;
      end
   end

   assign w_w_nxt = w_press_pulse | w_rpt_pulse;
`else
   assign w_w_nxt = w_press_pulse;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_w         <= 1'b0;
         r_btn_level <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_w         <= w_w_nxt;
         r_btn_level <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
      end
   end

   assign w         = r_w;
   assign btn_level = r_btn_level;
   assign state     = r_state;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed self-checking bench for button_pulse_gen (default DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10).
module tb_button_pulse_gen;

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int EXP_CLEAN = 2;
`else
   localparam int EXP_CLEAN = 1;
`endif

   logic       clk;
   logic       reset;
   logic       btn;
   logic       w;
   logic       btn_level;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;
   int p0;

   button_pulse_gen dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .w         (w),
      .btn_level (btn_level),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (w === 1'b1) n_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pat[6];
      pat = '{1, 1, 0, 1, 0, 1};

      reset = 1'b0;
      btn   = 1'b0;
      #2;
      check("reset_w", w, 0);
      check("reset_level", btn_level, 0);
      check("reset_state", state, 0);
      tick(2);
      reset = 1'b1;
      tick(3);
      check("idle_state", state, 0);

      // Clean press: first sampling edge N, pulse after edge N+6.
      p0  = n_pulses;
      btn = 1'b1;
      tick(6);
      check("clean_w_early", w, 0);
      check("clean_state_pw", state, 1);
      tick(1);
      check("clean_w", w, 1);
      check("clean_state", state, 2);
      check("clean_level", btn_level, 1);
      tick(1);
      check("clean_w_single", w, 0);
      tick(12);
      check("clean_pulses", n_pulses - p0, EXP_CLEAN);
      btn = 1'b0;
      tick(6);
      check("release_state_rw", state, 3);
      check("release_level_hold", btn_level, 1);
      tick(1);
      check("release_state_idle", state, 0);
      check("release_level", btn_level, 0);

      // Bounce 1,1,0,1,0,1 then held high.
      p0 = n_pulses;
      foreach (pat[i]) begin
         btn = pat[i][0];
         tick(1);
      end
      tick(5);
      check("bounce_no_w", n_pulses - p0, 0);
      check("bounce_state_pw", state, 1);
      tick(1);
      check("bounce_w", w, 1);

      // Release glitch of two cycles while pressed.
      tick(1);
      p0  = n_pulses;
      btn = 1'b0;
      tick(2);
      btn = 1'b1;
      tick(1);
      check("glitch_state_rw", state, 3);
      check("glitch_level_rw", btn_level, 1);
      tick(1);
      check("glitch_state_rw2", state, 3);
      tick(1);
      check("glitch_state_back", state, 2);
      check("glitch_level", btn_level, 1);
      tick(4);
      check("glitch_no_w", n_pulses - p0, 0);
      btn = 1'b0;
      tick(10);
      check("glitch_release_idle", state, 0);

      // Five back-to-back presses.
      p0 = n_pulses;
      for (int k = 0; k < 5; k++) begin
         btn = 1'b1;
         tick(10);
         btn = 1'b0;
         tick(10);
         check($sformatf("multi_idle_%0d", k), state, 0);
      end
      check("multi_pulses", n_pulses - p0, 5);

      // Reset during PRESS_WAIT, released with the button still held.
      btn = 1'b1;
      tick(4);
      check("rst_pre_state", state, 1);
      reset = 1'b0;
      #1;
      check("rst_w", w, 0);
      check("rst_level", btn_level, 0);
      check("rst_state", state, 0);
      tick(3);
      check("rst_state_hold", state, 0);
      p0    = n_pulses;
      reset = 1'b1;
      tick(6);
      check("rst_requal_w_early", w, 0);
      check("rst_requal_state", state, 1);
      tick(1);
      check("rst_requal_w", w, 1);
      tick(1);
      check("rst_requal_pulses", n_pulses - p0, 1);
      btn = 1'b0;
      tick(10);
      check("rst_release_idle", state, 0);

`ifdef BUTTON_AUTO_REPEAT_EN
      btn = 1'b1;
      tick(7);
      check("rpt_first_w", w, 1);
      tick(1);
      p0 = n_pulses;
      tick(8);
      check("rpt_w_gap", w, 0);
      tick(1);
      check("rpt_w_10", w, 1);
      tick(25);
      check("rpt_pulses", n_pulses - p0, 3);
      btn = 1'b0;
      tick(10);
      check("rpt_release_idle", state, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
